mv_search_sched: RTL

- Sequencer for one motion-vector search per macroblock. Generates the candidate MVs, drives the write-enable, MV and last-candidate strobes of the downstream SAD pipeline and MV selector, and waits for the selector's done pulse.
- Captures the winning MV/SAD and hands it to the consumer over a valid/ready handshake.
- Sits between the macroblock-level control and the SAD datapath / MV selector pair.

---
 rtl/me_pkg.sv | 29 ++
 rtl/mv_search_sched_if.sv | 41 ++++
 rtl/mv_cand_gen.sv | 49 ++++
 rtl/mv_search_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared widths, scheduler state type and the component saturation helper
// used by the motion-vector search scheduler.
package me_pkg;
    localparam int MV_W   = 14;
    localparam int COMP_W = 7;
    localparam int SAD_W  = 16;
    localparam int OFF_W  = 5;
    localparam int SUM_W  = COMP_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } sched_state_e;

    // Clamp an 8-bit signed component sum into the 7-bit range [-64, +63].
    function automatic logic [COMP_W-1:0] sat7(input logic signed [SUM_W-1:0] sum);
        logic [COMP_W-1:0] res;
        if (sum > 8'sd63) begin
            res = 7'h3F;
        end else if (sum < -8'sd64) begin
            res = 7'h40;
        end else begin
            res = sum[COMP_W-1:0];
        end
        return res;
    endfunction
endpackage

// File: rtl/mv_search_sched_if.sv
// Handshake bundle between the search scheduler and its neighbours.
// Define MV_SCHED_STATS_EN to add the cycle_cnt/stall_cnt statistics signals.
interface mv_search_sched_if;
    import me_pkg::*;

    logic              start;
    logic [MV_W-1:0]   center_mv;
    logic              issue_en;
    logic              WE;
    logic [MV_W-1:0]   MVout;
    logic              MVwait;
    logic              sel_done;
    logic [MV_W-1:0]   sel_mv;
    logic [SAD_W-1:0]  sel_sad;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [MV_W-1:0]   res_mv;
    logic [SAD_W-1:0]  res_sad;
    logic              err;
`ifdef MV_SCHED_STATS_EN
    logic [15:0]       cycle_cnt;
    logic [15:0]       stall_cnt;
`endif

    modport slave (
        input  start, center_mv, issue_en, sel_done, sel_mv, sel_sad, res_ready,
`ifdef MV_SCHED_STATS_EN
        output cycle_cnt, stall_cnt,
`endif
        output WE, MVout, MVwait, busy, res_valid, res_mv, res_sad, err
    );

    modport master (
        output start, center_mv, issue_en, sel_done, sel_mv, sel_sad, res_ready,
`ifdef MV_SCHED_STATS_EN
        input  cycle_cnt, stall_cnt,
`endif
        input  WE, MVout, MVwait, busy, res_valid, res_mv, res_sad, err
    );
endinterface

// File: rtl/mv_cand_gen.sv
// Candidate generator: raster offset counters (x inner, y outer), saturating
// centre+offset adder and the last-candidate flag.
module mv_cand_gen
    import me_pkg::*;
#(
    parameter int RANGE = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clear,
    input  logic            i_step,
    input  logic [MV_W-1:0] i_center,
    output logic [MV_W-1:0] o_mv,
    output logic            o_last
);
    localparam logic signed [OFF_W-1:0] OFF_MIN = OFF_W'(-RANGE);
    localparam logic signed [OFF_W-1:0] OFF_MAX = OFF_W'(RANGE);
    localparam logic signed [OFF_W-1:0] OFF_ONE = OFF_W'(1);

    logic signed [OFF_W-1:0] r_ox;
    logic signed [OFF_W-1:0] r_oy;
    logic signed [SUM_W-1:0] w_sum_x;
    logic signed [SUM_W-1:0] w_sum_y;

    // Offset counters; they park on the last candidate until the next clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ox <= '0;
            r_oy <= '0;
        end else if (i_clear) begin
            r_ox <= OFF_MIN;
            r_oy <= OFF_MIN;
        end else if (i_step && !o_last) begin
            if (r_ox == OFF_MAX) begin
                r_ox <= OFF_MIN;
                r_oy <= r_oy + OFF_ONE;
            end else begin
                r_ox <= r_ox + OFF_ONE;
            end
        end
    end

    assign w_sum_x = {i_center[MV_W-1], i_center[MV_W-1 -: COMP_W]}
                   + {{(SUM_W-OFF_W){r_ox[OFF_W-1]}}, r_ox};
    assign w_sum_y = {i_center[COMP_W-1], i_center[COMP_W-1:0]}
                   + {{(SUM_W-OFF_W){r_oy[OFF_W-1]}}, r_oy};
    assign o_mv    = {sat7(w_sum_x), sat7(w_sum_y)};
    assign o_last  = (r_ox == OFF_MAX) && (r_oy == OFF_MAX);
endmodule

// File: rtl/mv_search_sched.sv
// Motion-vector search sequencer: issues the candidate raster, waits for the
// selector and hands off the winner. Define MV_SCHED_STATS_EN for statistics.
module mv_search_sched
    import me_pkg::*;
#(
    parameter int RANGE         = 3,
    parameter int DRAIN_TIMEOUT = 31
) (
    input logic              clk,
    input logic              reset,
    mv_search_sched_if.slave bus
);
    localparam int               TMO_W    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    sched_state_e     r_state;
    sched_state_e     w_next;
    logic [MV_W-1:0]  r_center;
    logic             r_busy;
    logic             r_res_valid;
    logic [MV_W-1:0]  r_res_mv;
    logic [SAD_W-1:0] r_res_sad;
    logic             r_err;
    logic [TMO_W-1:0] r_tmo;

    logic             w_we;
    logic             w_accept;
    logic             w_capture;
    logic             w_timeout;
    logic             w_release;
    logic [MV_W-1:0]  w_mv;
    logic             w_last;

    mv_cand_gen #(.RANGE(RANGE)) u_cand (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_accept),
        .i_step   (w_we),
        .i_center (r_center),
        .o_mv     (w_mv),
        .o_last   (w_last)
    );

    // Next-state and per-cycle strobes.
    always_comb begin
        w_next    = r_state;
        w_we      = 1'b0;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        w_release = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = ST_ISSUE;
                end else begin
                    w_next   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.issue_en) begin
                    w_we   = 1'b1;
                    w_next = w_last ? ST_DRAIN : ST_ISSUE;
                end else begin
                    w_next = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (bus.sel_done) begin
                    w_capture = 1'b1;
                    w_next    = ST_OUT;
                end else if (r_tmo == TMO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end else begin
                    w_next    = ST_DRAIN;
                end
            end
            ST_OUT: begin
                if (bus.res_ready) begin
                    w_release = 1'b1;
                    w_next    = ST_IDLE;
                end else begin
                    w_next    = ST_OUT;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Centre latch, status flags, captured result and drain timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_center    <= '0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_mv    <= '0;
            r_res_sad   <= '0;
            r_err       <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_err <= w_timeout;
            if (w_accept) begin
                r_center <= bus.center_mv;
                r_busy   <= 1'b1;
            end else if (w_timeout || w_release) begin
                r_busy   <= 1'b0;
            end
            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_mv    <= bus.sel_mv;
                r_res_sad   <= bus.sel_sad;
            end else if (w_release) begin
                r_res_valid <= 1'b0;
            end
            // Counter restarts from zero on every DRAIN entry.
            if (r_state == ST_DRAIN) begin
                r_tmo <= r_tmo + TMO_ONE;
            end else begin
                r_tmo <= '0;
            end
        end
    end

    assign bus.WE        = w_we;
    assign bus.MVout     = w_mv;
    assign bus.MVwait    = w_we & w_last;
    assign bus.busy      = r_busy;
    assign bus.res_valid = r_res_valid;
    assign bus.res_mv    = r_res_mv;
    assign bus.res_sad   = r_res_sad;
    assign bus.err       = r_err;

`ifdef MV_SCHED_STATS_EN
    logic [15:0] r_run;
    logic [15:0] r_cycle_cnt;
    logic [15:0] r_stall_cnt;

    // Saturating search-latency and issue-stall counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run       <= 16'h0000;
            r_cycle_cnt <= 16'h0000;
            r_stall_cnt <= 16'h0000;
        end else if (w_accept) begin
            r_run       <= 16'h0001;
            r_cycle_cnt <= 16'h0000;
            r_stall_cnt <= 16'h0000;
        end else begin
            if (r_busy && (r_run != 16'hFFFF)) begin
                r_run <= r_run + 16'h0001;
            end
            if (w_capture) begin
                r_cycle_cnt <= (r_run == 16'hFFFF) ? 16'hFFFF : r_run + 16'h0001;
            end
            if ((r_state == ST_ISSUE) && !bus.issue_en && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'h0001;
            end
        end
    end

    assign bus.cycle_cnt = r_cycle_cnt;
    assign bus.stall_cnt = r_stall_cnt;
`endif
endmodule
